// File: rtl/param_stack_pkg.sv
// Shared definitions for the parametrised LIFO (param_stack).
//  - OP_* : request encoding {pop, push} as decoded by the top level.
//  - ptr_width() : width of an occupancy counter able to hold 0..depth.
package param_stack_pkg;

   // Request encoding, bit 1 = pop, bit 0 = push.
   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_PUSH    = 2'b01;
   localparam logic [1:0] OP_POP     = 2'b10;
   localparam logic [1:0] OP_REPLACE = 2'b11;

   // Counter width covering 0..depth inclusive.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/param_stack_if.sv
// Request/response bundle for param_stack.
//  master : drives init, push, push_data, pop; observes everything else.
//  slave  : the stack itself.
//  Signals: init, push, push_data[WIDTH], pop, pop_data[WIDTH], pop_valid,
//           top[WIDTH], count[ptr_width(DEPTH)], full, empty, almost_full,
//           overflow_err, underflow_err.
interface param_stack_if
   import param_stack_pkg::*;
#(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 256
);
   localparam int unsigned CNT_W = ptr_width(DEPTH);

   logic             init;
   logic             push;
   logic [WIDTH-1:0] push_data;
   logic             pop;
   logic [WIDTH-1:0] pop_data;
   logic             pop_valid;
   logic [WIDTH-1:0] top;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             overflow_err;
   logic             underflow_err;

   modport master (
      output init, push, push_data, pop,
      input  pop_data, pop_valid, top, count, full, empty, almost_full,
             overflow_err, underflow_err
   );

   modport slave (
      input  init, push, push_data, pop,
      output pop_data, pop_valid, top, count, full, empty, almost_full,
             overflow_err, underflow_err
   );

endinterface

// File: rtl/param_stack_ptr.sv
// Occupancy counter for param_stack.
//  clk, rst_n   : clock, asynchronous active-low reset
//  clr          : synchronous clear (highest priority)
//  inc, dec     : step up / down; caller guarantees they never over/underflow
//  count        : current occupancy 0..DEPTH
//  full, empty, almost_full : decoded from the count register only
module param_stack_ptr #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned AF_MARGIN = 2,
   parameter int unsigned CNT_W     = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             almost_full
);

   localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(DEPTH - AF_MARGIN);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CNT_W'(1);
      end else if (dec) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count       = count_q;
   assign full        = (count_q == FULL_LEVEL);
   assign empty       = (count_q == '0);
   assign almost_full = (count_q >= AF_LEVEL);

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with replace-top, registered pop + valid strobe and a
// combinational top-of-stack peek.
//  clk, rst_n : clock, asynchronous active-low reset (memory is not reset)
//  bus        : param_stack_if.slave (init/push/pop requests, pop_data,
//               pop_valid, top, count, full, empty, almost_full, sticky errs)
//  Priority per cycle: init > replace > push > pop.
//  Optional macro PARAM_STACK_ERR_EN: when defined, overflow_err/underflow_err
//  are sticky flags set by rejected push/pop; otherwise both are tied 0.
module param_stack
   import param_stack_pkg::*;
#(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned AF_MARGIN = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   param_stack_if.slave   bus
);

   localparam int unsigned CNT_W = ptr_width(DEPTH);
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             almost_full;

   logic [1:0]       op;
   logic             do_push;
   logic             do_pop;
   logic             do_repl;
   logic [AW-1:0]    top_addr;
   logic [AW-1:0]    wr_addr;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] pop_data_q;
   logic             pop_valid_q;

   // Request decode
   assign op = {bus.pop, bus.push};

   always_comb begin
      do_push = 1'b0;
      do_pop  = 1'b0;
      do_repl = 1'b0;
      if (!bus.init) begin
         case (op)
            OP_PUSH:    do_push = !full;
            OP_POP:     do_pop  = !empty;
            // On an empty stack push+pop degrades to a plain push.
            OP_REPLACE: begin
               if (empty) begin
                  do_push = 1'b1;
               end else begin
                  do_repl = 1'b1;
               end
            end
            default:    ;
         endcase
      end
   end

   // Addressing: top lives at count-1, next free slot at count.
   assign top_addr = AW'(count - CNT_W'(1));
   assign wr_addr  = do_repl ? top_addr : AW'(count);

   always_ff @(posedge clk) begin
      if (do_push || do_repl) begin
         mem[wr_addr] <= bus.push_data;
      end
   end

   // Replace reads the old top in the same edge that overwrites it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
      end else if (do_pop || do_repl) begin
         pop_data_q  <= mem[top_addr];
         pop_valid_q <= 1'b1;
      end else begin
         pop_valid_q <= 1'b0;
      end
   end

   param_stack_ptr #(
      .DEPTH     (DEPTH),
      .AF_MARGIN (AF_MARGIN),
      .CNT_W     (CNT_W)
   ) u_ptr (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (bus.init),
      .inc         (do_push),
      .dec         (do_pop),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full)
   );

`ifdef PARAM_STACK_ERR_EN
   logic ovf_evt;
   logic unf_evt;
   logic overflow_q;
   logic underflow_q;

   // Push+pop on empty still counts as a rejected pop.
   assign ovf_evt = !bus.init && bus.push && !bus.pop && full;
   assign unf_evt = !bus.init && bus.pop && empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.init) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_q  | ovf_evt;
         underflow_q <= underflow_q | unf_evt;
      end
   end

   assign bus.overflow_err  = overflow_q;
   assign bus.underflow_err = underflow_q;
`else
   assign bus.overflow_err  = 1'b0;
   assign bus.underflow_err = 1'b0;
`endif

   assign bus.pop_data    = pop_data_q;
   assign bus.pop_valid   = pop_valid_q;
   assign bus.top         = empty ? '0 : mem[top_addr];
   assign bus.count       = count;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.almost_full = almost_full;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack (WIDTH=4, DEPTH=4, AF_MARGIN=1).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_param_stack;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 4;

`ifdef PARAM_STACK_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   param_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   param_stack #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AF_MARGIN (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic i, input logic ps, input logic pp, input logic [3:0] d);
      bus.init      = i;
      bus.push      = ps;
      bus.pop       = pp;
      bus.push_data = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 4'h0);
      #12;
      total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
      total++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
         bad++; $display("FAIL reset_flags got e=%b f=%b af=%b want 1 0 0", bus.empty, bus.full, bus.almost_full); end
      total++; if (bus.pop_valid !== 1'b0 || bus.pop_data !== 4'h0 || bus.top !== 4'h0) begin
         bad++; $display("FAIL reset_pop got v=%b d=%0h top=%0h want 0 0 0", bus.pop_valid, bus.pop_data, bus.top); end
      total++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
         bad++; $display("FAIL reset_err got o=%b u=%b want 0 0", bus.overflow_err, bus.underflow_err); end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_push_fill();
      for (int i = 1; i <= 4; i++) begin
         drive(0, 1, 0, 4'(i));
         cyc();
         total++; if (bus.count !== 3'(i) || bus.top !== 4'(i)) begin
            bad++; $display("FAIL fill_%0d got count=%0d top=%0h want %0d %0h", i, bus.count, bus.top, i, i); end
         total++; if (bus.almost_full !== (i >= 3) || bus.full !== (i == 4) || bus.empty !== 1'b0) begin
            bad++; $display("FAIL fill_flags_%0d got af=%b f=%b e=%b", i, bus.almost_full, bus.full, bus.empty); end
      end
      drive(0, 0, 0, 4'h0);
   endtask

   task automatic test_pop_drain();
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 1, 4'h0);
         cyc();
         total++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 4'(5 - i) || bus.count !== 3'(4 - i)) begin
            bad++; $display("FAIL drain_%0d got v=%b d=%0h count=%0d want 1 %0h %0d",
                            i, bus.pop_valid, bus.pop_data, bus.count, 5 - i, 4 - i); end
      end
      drive(0, 0, 0, 4'h0);
      cyc();
      total++; if (bus.pop_valid !== 1'b0 || bus.empty !== 1'b1 || bus.top !== 4'h0) begin
         bad++; $display("FAIL drain_end got v=%b e=%b top=%0h want 0 1 0", bus.pop_valid, bus.empty, bus.top); end
   endtask

   task automatic test_replace();
      drive(0, 1, 0, 4'h1); cyc();
      drive(0, 1, 0, 4'h2); cyc();
      drive(0, 1, 1, 4'h9); cyc();
      total++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 4'h2) begin
         bad++; $display("FAIL replace_pop got v=%b d=%0h want 1 2", bus.pop_valid, bus.pop_data); end
      total++; if (bus.top !== 4'h9 || bus.count !== 3'd2) begin
         bad++; $display("FAIL replace_top got top=%0h count=%0d want 9 2", bus.top, bus.count); end
      drive(0, 0, 0, 4'h0); cyc();
      total++; if (bus.pop_valid !== 1'b0) begin
         bad++; $display("FAIL replace_strobe got v=%b want 0", bus.pop_valid); end
   endtask

   task automatic test_overflow();
      // stack holds [1, 9]; fill with 5, 6
      drive(0, 1, 0, 4'h5); cyc();
      drive(0, 1, 0, 4'h6); cyc();
      drive(0, 1, 0, 4'h7); cyc();
      total++; if (bus.count !== 3'd4 || bus.top !== 4'h6 || bus.full !== 1'b1 || bus.pop_valid !== 1'b0) begin
         bad++; $display("FAIL ovf_state got count=%0d top=%0h f=%b v=%b want 4 6 1 0",
                         bus.count, bus.top, bus.full, bus.pop_valid); end
      drive(0, 0, 0, 4'h0); cyc();
      total++; if (bus.overflow_err !== ERR_ON || bus.underflow_err !== 1'b0) begin
         bad++; $display("FAIL ovf_sticky got o=%b u=%b want %b 0", bus.overflow_err, bus.underflow_err, ERR_ON); end
      // replace on a full stack is legal and must not flag overflow
      drive(0, 1, 1, 4'hB); cyc();
      total++; if (bus.pop_data !== 4'h6 || bus.top !== 4'hB || bus.count !== 3'd4) begin
         bad++; $display("FAIL full_replace got d=%0h top=%0h count=%0d want 6 b 4", bus.pop_data, bus.top, bus.count); end
      drive(1, 0, 0, 4'h0); cyc();
      total++; if (bus.count !== 3'd0 || bus.overflow_err !== 1'b0 || bus.empty !== 1'b1) begin
         bad++; $display("FAIL ovf_init got count=%0d o=%b e=%b want 0 0 1", bus.count, bus.overflow_err, bus.empty); end
      drive(0, 0, 0, 4'h0);
   endtask

   task automatic test_underflow();
      drive(0, 0, 1, 4'h0); cyc();
      total++; if (bus.pop_valid !== 1'b0 || bus.count !== 3'd0 || bus.pop_data !== 4'h6) begin
         bad++; $display("FAIL unf_pop got v=%b count=%0d d=%0h want 0 0 6", bus.pop_valid, bus.count, bus.pop_data); end
      total++; if (bus.underflow_err !== ERR_ON || bus.overflow_err !== 1'b0) begin
         bad++; $display("FAIL unf_err got u=%b o=%b want %b 0", bus.underflow_err, bus.overflow_err, ERR_ON); end
      // push+pop on empty acts as a plain push
      drive(0, 1, 1, 4'hA); cyc();
      total++; if (bus.count !== 3'd1 || bus.top !== 4'hA || bus.pop_valid !== 1'b0) begin
         bad++; $display("FAIL empty_pp got count=%0d top=%0h v=%b want 1 a 0", bus.count, bus.top, bus.pop_valid); end
      drive(1, 0, 0, 4'h0); cyc();
      total++; if (bus.underflow_err !== 1'b0 || bus.count !== 3'd0) begin
         bad++; $display("FAIL unf_init got u=%b count=%0d want 0 0", bus.underflow_err, bus.count); end
      drive(0, 0, 0, 4'h0);
   endtask

   task automatic test_back_to_back();
      drive(0, 1, 0, 4'h3); cyc();
      drive(0, 1, 0, 4'h5); cyc();
      drive(0, 0, 1, 4'h0); cyc();
      total++; if (bus.pop_data !== 4'h5 || bus.pop_valid !== 1'b1 || bus.top !== 4'h3) begin
         bad++; $display("FAIL b2b_pop1 got d=%0h v=%b top=%0h want 5 1 3", bus.pop_data, bus.pop_valid, bus.top); end
      drive(0, 1, 0, 4'hE); cyc();
      total++; if (bus.pop_valid !== 1'b0 || bus.top !== 4'hE || bus.count !== 3'd2) begin
         bad++; $display("FAIL b2b_push got v=%b top=%0h count=%0d want 0 e 2", bus.pop_valid, bus.top, bus.count); end
      drive(0, 0, 1, 4'h0); cyc();
      total++; if (bus.pop_data !== 4'hE || bus.pop_valid !== 1'b1) begin
         bad++; $display("FAIL b2b_pop2 got d=%0h v=%b want e 1", bus.pop_data, bus.pop_valid); end
      cyc();
      total++; if (bus.pop_data !== 4'h3 || bus.pop_valid !== 1'b1 || bus.count !== 3'd0) begin
         bad++; $display("FAIL b2b_pop3 got d=%0h v=%b count=%0d want 3 1 0", bus.pop_data, bus.pop_valid, bus.count); end
      drive(0, 0, 0, 4'h0); cyc();
   endtask

   task automatic test_reset_mid();
      for (int i = 1; i <= 3; i++) begin
         drive(0, 1, 0, 4'(i)); cyc();
      end
      total++; if (bus.count !== 3'd3) begin
         bad++; $display("FAIL mid_setup got count=%0d want 3", bus.count); end
      drive(0, 0, 1, 4'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus.count !== 3'd0 || bus.pop_valid !== 1'b0 || bus.pop_data !== 4'h0) begin
         bad++; $display("FAIL mid_reset got count=%0d v=%b d=%0h want 0 0 0", bus.count, bus.pop_valid, bus.pop_data); end
      drive(0, 0, 0, 4'h0);
      #1;
      rst_n = 1'b1;
      cyc();
      // same scenario using the synchronous clear
      for (int i = 1; i <= 3; i++) begin
         drive(0, 1, 0, 4'(i)); cyc();
      end
      drive(0, 0, 1, 4'h0); cyc();
      total++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 4'h3) begin
         bad++; $display("FAIL init_pre got v=%b d=%0h want 1 3", bus.pop_valid, bus.pop_data); end
      drive(1, 1, 1, 4'hF); cyc();
      total++; if (bus.count !== 3'd0 || bus.pop_valid !== 1'b0 || bus.pop_data !== 4'h3 || bus.top !== 4'h0) begin
         bad++; $display("FAIL init_clear got count=%0d v=%b d=%0h top=%0h want 0 0 3 0",
                         bus.count, bus.pop_valid, bus.pop_data, bus.top); end
      drive(0, 0, 0, 4'h0); cyc();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_push_fill();
      test_pop_drain();
      test_replace();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
